scan_mux_reg: RTL and testbench

//  Registered N-channel, W-bit-wide multiplexer with valid/ready output handshake.

---
 rtl/scan_mux_reg.sv | 109 ++++++++++
 tb/tb_scan_mux_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scan_mux_reg.sv
// Purpose: registered N:1 channel mux with MANUAL (selector) and SCAN (round-robin dwell) modes.
// Latency: 1 cycle from load to output; the first load follows enable by one cycle.
// Backpressure: output_valid holds output_line/chan/sel_error stable until output_ready.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   input_lines    NUM_CHANNELS packed channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   selector_bits  channel select (MANUAL only)
//   enable, mode   enable=0 -> IDLE; mode 0 = MANUAL, 1 = SCAN
//   output_ready   consumer accepts output this cycle
//   output_line    registered sample; output_valid qualifies it
//   output_chan    channel the sample came from
//   sel_error      sample taken with an out-of-range selector
module scan_mux_reg #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DWELL_CYCLES = 4,
  localparam int SEL_W       = $clog2(NUM_CHANNELS),
  localparam int DW_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] input_lines,
  input  logic [SEL_W-1:0]                   selector_bits,
  input  logic                               enable,
  input  logic                               mode,
  input  logic                               output_ready,
  output logic [DATA_WIDTH-1:0]              output_line,
  output logic                               output_valid,
  output logic [SEL_W-1:0]                   output_chan,
  output logic                               sel_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [SEL_W-1:0]      scan_ptr;
  logic [DW_W-1:0]       dwell_cnt;
  logic [SEL_W-1:0]      chan_sel;
  logic [DATA_WIDTH-1:0] mux_dat;
  logic                  sel_oor;
  logic                  enter_scan;
  logic                  load;

  always_comb begin
    next_state = IDLE;
    if (enable) next_state = mode ? SCAN : MANUAL;
  end

  // Entering SCAN restarts the pointer; that edge carries no load so the
  // first scan sample is always channel 0.
  assign enter_scan = (next_state == SCAN) && (state != SCAN);
  assign load       = (state != IDLE) && (!output_valid || output_ready) && !enter_scan;

  assign chan_sel = (state == SCAN) ? scan_ptr : selector_bits;
  assign sel_oor  = (state == MANUAL) &&
                    ({1'b0, selector_bits} >= (SEL_W+1)'(NUM_CHANNELS));

  // An out-of-range select matches no channel, so the data falls back to zero.
  always_comb begin
    mux_dat = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (chan_sel == SEL_W'(k)) mux_dat = input_lines[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      scan_ptr     <= '0;
      dwell_cnt    <= '0;
      output_line  <= '0;
      output_valid <= 1'b0;
      output_chan  <= '0;
      sel_error    <= 1'b0;
    end else begin
      state <= next_state;

      if (load) begin
        output_line  <= mux_dat;
        output_chan  <= chan_sel;
        sel_error    <= sel_oor;
        output_valid <= 1'b1;
        // Dwell counts loads only; stalled cycles leave the pointer alone.
        if (state == SCAN) begin
          if (dwell_cnt == DW_W'(DWELL_CYCLES - 1)) begin
            dwell_cnt <= '0;
            scan_ptr  <= (scan_ptr == SEL_W'(NUM_CHANNELS - 1)) ? '0 : scan_ptr + 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
      end else if (output_valid && output_ready) begin
        output_valid <= 1'b0;
      end

      if (enter_scan) begin
        scan_ptr  <= '0;
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux_reg.sv
module tb_scan_mux_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance, dwell 4
  logic [31:0] lines4;
  logic [1:0]  sel4;
  logic        en4, mode4, rdy4;
  logic [7:0]  line4;
  logic        vld4;
  logic [1:0]  chan4;
  logic        err4;

  // 3-channel instance, exposes the out-of-range selector
  logic [23:0] lines3;
  logic [1:0]  sel3;
  logic        en3, mode3, rdy3;
  logic [7:0]  line3;
  logic        vld3;
  logic [1:0]  chan3;
  logic        err3;

  int total = 0;
  int bad   = 0;

  scan_mux_reg #(.NUM_CHANNELS(4), .DATA_WIDTH(8), .DWELL_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .input_lines(lines4), .selector_bits(sel4),
    .enable(en4), .mode(mode4), .output_ready(rdy4), .output_line(line4),
    .output_valid(vld4), .output_chan(chan4), .sel_error(err4)
  );

  scan_mux_reg #(.NUM_CHANNELS(3), .DATA_WIDTH(8), .DWELL_CYCLES(4)) u3 (
    .clk(clk), .rst_n(rst_n), .input_lines(lines3), .selector_bits(sel3),
    .enable(en3), .mode(mode3), .output_ready(rdy3), .output_line(line3),
    .output_valid(vld3), .output_chan(chan3), .sel_error(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte c of a packed line word.
  function automatic logic [7:0] ch_dat(input logic [31:0] l, input int c);
    return 8'(l >> (c * 8));
  endfunction

  // Transaction-level scan model: the k-th accepted sample after entering SCAN
  // comes from channel (k / DWELL) mod N. Stalled samples must hold still.
  task automatic scan_run(input int n_xfer, input bit rand_ready, input string tag);
    int k = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [7:0] sl = '0;
    logic [1:0] sc = '0;
    logic r;
    int ec;
    while (k < n_xfer && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk({tag, "_hold_line"}, line4, sl);
        chk({tag, "_hold_chan"}, chan4, sc);
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy4 = r;
      if (vld4 && r) begin
        ec = (k / 4) % 4;
        chk({tag, "_chan"}, chan4, ec);
        chk({tag, "_data"}, line4, ch_dat(lines4, ec));
        k++;
      end
      stall = vld4 && !r;
      sl = line4;
      sc = chan4;
    end
    chk({tag, "_xfer_count"}, k, n_xfer);
  endtask

  initial begin
    lines4 = '0; sel4 = '0; en4 = 1'b0; mode4 = 1'b0; rdy4 = 1'b0;
    lines3 = '0; sel3 = '0; en3 = 1'b0; mode3 = 1'b0; rdy3 = 1'b0;

    // Reset state
    #12;
    chk("rst_vld", vld4, 0);
    chk("rst_line", line4, 0);
    chk("rst_chan", chan4, 0);
    chk("rst_err", err4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MANUAL select, first load two edges after enable
    @(negedge clk);
    lines4 = 32'h4433_2211; sel4 = 2'd2; mode4 = 1'b0; rdy4 = 1'b1; en4 = 1'b1;
    @(negedge clk);
    chk("man_first_edge_vld", vld4, 0);
    @(negedge clk);
    chk("man_vld", vld4, 1);
    chk("man_line", line4, 8'h33);
    chk("man_chan", chan4, 2);
    chk("man_err", err4, 0);
    repeat (3) begin
      @(negedge clk);
      chk("man_held_line", line4, 8'h33);
      chk("man_held_vld", vld4, 1);
    end

    // Backpressure holds the sample while the selector moves
    rdy4 = 1'b0; sel4 = 2'd0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_line", line4, 8'h33);
      chk("bp_chan", chan4, 2);
      chk("bp_vld", vld4, 1);
    end
    rdy4 = 1'b1;
    @(negedge clk);
    chk("bp_release_line", line4, 8'h11);
    chk("bp_release_chan", chan4, 0);

    // SCAN with ready always high, random channel data
    lines4 = $urandom;
    mode4 = 1'b1;
    scan_run(17, 1'b0, "scan");

    // Going IDLE with a pending sample keeps it valid until accepted
    en4 = 1'b0; rdy4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_pending_vld", vld4, 1);
    rdy4 = 1'b1;
    @(negedge clk);
    chk("idle_drained_vld", vld4, 0);

    // SCAN restart with random ready: no dropped or duplicated samples
    lines4 = $urandom;
    en4 = 1'b1; mode4 = 1'b1;
    scan_run(32, 1'b1, "scan_rr");

    // Asynchronous reset mid-scan at channel 2
    en4 = 1'b0; rdy4 = 1'b1;
    repeat (3) @(negedge clk);
    lines4 = $urandom;
    en4 = 1'b1; mode4 = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_chan", chan4, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vld4, 0);
    chk("arst_line", line4, 0);
    chk("arst_chan", chan4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_enter_vld", vld4, 0);
    @(negedge clk);
    chk("post_rst_vld", vld4, 1);
    chk("post_rst_chan", chan4, 0);
    chk("post_rst_line", line4, ch_dat(lines4, 0));

    // Out-of-range selector on the 3-channel instance
    @(negedge clk);
    lines3 = 24'($urandom); sel3 = 2'd3; mode3 = 1'b0; rdy3 = 1'b1; en3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("oor_vld", vld3, 1);
    chk("oor_line", line3, 0);
    chk("oor_err", err3, 1);
    chk("oor_chan", chan3, 3);
    sel3 = 2'd1;
    @(negedge clk);
    chk("inr1_line", line3, ch_dat({8'h00, lines3}, 1));
    chk("inr1_err", err3, 0);
    chk("inr1_chan", chan3, 1);
    sel3 = 2'd2;
    @(negedge clk);
    chk("inr2_line", line3, ch_dat({8'h00, lines3}, 2));
    chk("inr2_err", err3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
